// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel-to-serial front end feeding a serial sequence detector
//
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock on x. A one-word holding register lets consecutive words
// stream with no idle cycle between them.
//
// Build option: define SERIAL_FEEDER_LSB_FIRST_EN for LSB-first bit order;
// otherwise words leave MSB first. Only the bit order changes.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   din        in   [WIDTH-1:0] parallel word, sampled only on accept
//   din_valid  in   din is valid this cycle
//   din_ready  out  a word can be accepted this cycle
//   x          out  serial bit to the detector, 0 when x_valid is 0
//   x_valid    out  x carries a word bit this cycle
//   last       out  x carries the final bit of the current word
//   busy       out  a word is shifting or a word is held

module serial_bit_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic             out_bit;
    logic [WIDTH-1:0] shreg_shifted;

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    assign out_bit       = shreg_q[0];
    assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
`else
    assign out_bit       = shreg_q[WIDTH-1];
    assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
`endif

    // Gating with reset keeps ready low during reset even though the flops
    // already read zero, so no word can slip in on the release edge early.
    assign din_ready = reset & ~hold_full_q;
    assign accept    = din_valid & din_ready;

    assign x_valid = (state_q == SHIFT);
    assign x       = (state_q == SHIFT) & out_bit;
    assign last    = (state_q == SHIFT) & (cnt_q == '0);
    assign busy    = (state_q == SHIFT) | hold_full_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = din;
                    cnt_d   = CNT_MAX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q - CW'(1);
                    // din_ready is low while hold is full, so this never
                    // overwrites a held word.
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    shreg_d     = hold_q;
                    cnt_d       = CNT_MAX;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    // Word arriving on the retiring edge goes straight to
                    // the shifter; parking it in hold would cost a bubble.
                    shreg_d = din;
                    cnt_d   = CNT_MAX;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, x, x_valid, last, busy;

    logic [3:0] din4;
    logic       din_valid4;
    logic       din_ready4, x4, x_valid4, last4, busy4;

    int tests = 0;
    int fails = 0;

    logic [1:0] sb[$];   // {last, bit}

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid), .last(last), .busy(busy)
    );

    serial_bit_feeder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .din(din4), .din_valid(din_valid4),
        .din_ready(din_ready4), .x(x4), .x_valid(x_valid4), .last(last4), .busy(busy4)
    );

    // Reference 1001 detector (Mealy, overlapping), cleared whenever x is idle.
    logic [2:0] hist;
    logic       y;
    assign y = x_valid & x & (hist == 3'b100);
    always @(posedge clk or negedge reset) begin
        if (!reset)       hist <= 3'b000;
        else if (x_valid) hist <= {hist[1:0], x};
        else              hist <= 3'b000;
    end

    function automatic logic exp_bit(input logic [31:0] w, input int k, input int width);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        return w[k];
`else
        return w[width-1-k];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on every accept edge.
    always @(posedge clk) begin
        if (reset && din_valid && din_ready) begin
            for (int k = 0; k < 8; k++)
                sb.push_back({(k == 7), exp_bit({24'd0, din}, k, 8)});
        end
    end

    // Scoreboard pop/compare, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] e;
        if (reset) begin
            if (x_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", x_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("x_bit", x, e[0]);
                    chk("last", last, e[1]);
                end
            end else begin
                chk("x_zero_idle", x, 1'b0);
                if (sb.size() != 0) chk("stream_gap", x_valid, 1'b1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!din_ready && n < 40) begin
            step();
            n++;
        end
        chk(tag, din_ready, 1'b1);
    endtask

    // Present w and return 2 time units after the accept edge (bit 0 on x).
    task automatic send_word(input logic [7:0] w);
        wait_ready("ready_timeout");
        din       = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        din        = 8'h96;
        din_valid  = 1'b1;
        din4       = 4'h0;
        din_valid4 = 1'b0;

        // Reset held with din_valid high: everything quiet.
        step();
        step();
        chk("rst_x", x, 1'b0);
        chk("rst_x_valid", x_valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_din_ready", din_ready, 1'b0);

        // Release: ready in the same cycle, accept at the first edge.
        reset = 1'b1;
        #1;
        chk("rel_din_ready", din_ready, 1'b1);
        @(posedge clk);
        #2;
        din_valid = 1'b0;
        chk("first_accept_valid", x_valid, 1'b1);
        chk("first_accept_bit", x, exp_bit(32'h96, 0, 8));
        wait_idle();
        chk("single_idle_x", x, 1'b0);
        chk("single_idle_sb", sb.size(), 0);

        // Back-to-back 96, F0, 0F.
        send_word(8'h96);
        send_word(8'hF0);
        chk("hold_ready_low", din_ready, 1'b0);
        chk("hold_busy", busy, 1'b1);
        wait_ready("hold_release");
        chk("hold_release_at_f0_load", sb.size(), 8);
        send_word(8'h0F);
        wait_idle();
        chk("b2b_sb_drained", sb.size(), 0);

        // Detector chain: 1001_1001, y on the 4th bit.
        step();
        send_word(8'h99);
        chk("det_bit0", y, 1'b0);
        step();
        step();
        chk("det_bit2", y, 1'b0);
        step();
        chk("det_bit3_x", x, 1'b1);
        chk("det_bit3_y", y, 1'b1);
        wait_idle();

        // Reset mid-word at bit 3 with a word held.
        send_word(8'h96);
        send_word(8'hF0);
        step();
        step();
        chk("mid_hold_full", din_ready, 1'b0);
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("async_x", x, 1'b0);
        chk("async_x_valid", x_valid, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_last", last, 1'b0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("post_rst_x_valid", x_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        // WIDTH=4 instance, word 0110.
        din4       = 4'b0110;
        din_valid4 = 1'b1;
        chk("w4_ready", din_ready4, 1'b1);
        step();
        din_valid4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("w4_valid", x_valid4, 1'b1);
            chk("w4_bit", x4, exp_bit(32'h6, k, 4));
            chk("w4_last", last4, (k == 3));
            step();
        end
        chk("w4_idle", x_valid4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
